// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// state encoding and the fixed datapath widths.
package mult_seq_pkg;

  localparam int MULT_WIDTH = 9;
  localparam int MULT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_rc_9_instant.sv
// Ripple-carry adder shared by the multiplier; S carries the carry-out
// in its top bit so the shift step can use it directly.
module adder_rc_9_instant #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   S
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign S[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
  end

  assign S[WIDTH] = carry[WIDTH];

endmodule

// File: rtl/mult_seq_9.sv
// Sequential unsigned multiplier: one adder pass per cycle over WIDTH cycles.
// Optional MULT_ZERO_BYPASS_EN sends zero-operand requests straight to DONE.
module mult_seq_9
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t state_q, state_d;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  // Adder adds the multiplicand only when the multiplier bit under the shift is set.
  assign addend = lo_q[0] ? mcand_q : '0;

  adder_rc_9_instant #(
    .WIDTH(WIDTH)
  ) u_adder (
    .A(hi_q),
    .B(addend),
    .S(sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          count_d = '0;
          state_d = ST_RUN;
`ifdef MULT_ZERO_BYPASS_EN
          if ((a == '0) || (b == '0)) begin
            state_d   = ST_DONE;
            product_d = '0;
          end
`endif
        end
      end

      ST_RUN: begin
        hi_d    = sum[WIDTH:1];
        lo_d    = {sum[0], lo_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        // The last step's shifted value is captured straight into the product.
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d   = ST_DONE;
          product_d = {sum[WIDTH:1], sum[0], lo_q[WIDTH-1:1]};
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready   = (state_q == ST_IDLE);
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule
